// File: rtl/xge_mac_stat_reg_block.sv
// Statistics/status register block: CONFIG, STATUS, W1C interrupt status/mask and saturating counters.
// Optional macro XGE_MAC_STAT_CLR_ON_READ_EN makes counter reads destructive.
module xge_mac_stat_reg_block #(
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 32,
  parameter int BASE_ADDRESS   = 0,
  parameter int NUM_CNT        = 4,
  parameter logic [REG_DATA_WIDTH-1:0] CFG_RESET = 'h4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [REG_ADDR_WIDTH-1:0] regb_addr_i,
  input  logic [REG_DATA_WIDTH-1:0] regb_wdata_i,
  input  logic                      regb_wen_i,
  input  logic                      regb_ren_i,
  output logic [REG_DATA_WIDTH-1:0] regb_rdata_o,
  output logic                      regb_ack_o,
  output logic                      regb_error_o,
  input  logic [NUM_CNT-1:0]        cnt_inc_i,
  input  logic [REG_DATA_WIDTH-1:0] status_i,
  output logic [REG_DATA_WIDTH-1:0] cfg_o,
  output logic                      irq_o
);

`ifdef XGE_MAC_STAT_CLR_ON_READ_EN
  localparam bit CLR_ON_READ = 1'b1;
`else
  localparam bit CLR_ON_READ = 1'b0;
`endif

  localparam logic [REG_ADDR_WIDTH-1:0] A_CFG = REG_ADDR_WIDTH'(BASE_ADDRESS + 'h0);
  localparam logic [REG_ADDR_WIDTH-1:0] A_STA = REG_ADDR_WIDTH'(BASE_ADDRESS + 'h4);
  localparam logic [REG_ADDR_WIDTH-1:0] A_IST = REG_ADDR_WIDTH'(BASE_ADDRESS + 'h8);
  localparam logic [REG_ADDR_WIDTH-1:0] A_MSK = REG_ADDR_WIDTH'(BASE_ADDRESS + 'hC);
  localparam logic [REG_DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [REG_DATA_WIDTH-1:0] CNT_PRE = CNT_MAX - REG_DATA_WIDTH'(1);

  logic [REG_DATA_WIDTH-1:0] cfg_q;
  logic [NUM_CNT-1:0]        int_status;
  logic [NUM_CNT-1:0]        int_mask;
  logic [REG_DATA_WIDTH-1:0] cnt [NUM_CNT];

  logic                      hit_cfg, hit_sta, hit_ist, hit_msk;
  logic [NUM_CNT-1:0]        hit_cnt;
  logic [REG_DATA_WIDTH-1:0] rd_val;
  logic                      req, err, wr_ok, rd_ok;
  logic [NUM_CNT-1:0]        clr_rd, sat_set;

  always_comb begin
    hit_cfg = (regb_addr_i == A_CFG);
    hit_sta = (regb_addr_i == A_STA);
    hit_ist = (regb_addr_i == A_IST);
    hit_msk = (regb_addr_i == A_MSK);
    hit_cnt = '0;
    rd_val  = '0;
    if (hit_cfg) rd_val = cfg_q;
    if (hit_sta) rd_val = status_i;
    if (hit_ist) rd_val = REG_DATA_WIDTH'(int_status);
    if (hit_msk) rd_val = REG_DATA_WIDTH'(int_mask);
    for (int i = 0; i < NUM_CNT; i++) begin
      hit_cnt[i] = (regb_addr_i == REG_ADDR_WIDTH'(BASE_ADDRESS + 16 + 4 * i));
      if (hit_cnt[i]) rd_val = cnt[i];
    end
  end

  // Erroring requests are acked but must not touch any register.
  assign req   = regb_wen_i | regb_ren_i;
  assign err   = (regb_wen_i & regb_ren_i)
               | ~(hit_cfg | hit_sta | hit_ist | hit_msk | (|hit_cnt))
               | (regb_wen_i & (hit_sta | (|hit_cnt)));
  assign wr_ok = regb_wen_i & ~err;
  assign rd_ok = regb_ren_i & ~err;

  always_comb begin
    clr_rd  = '0;
    sat_set = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      clr_rd[i]  = CLR_ON_READ & rd_ok & hit_cnt[i];
      sat_set[i] = cnt_inc_i[i] & ~clr_rd[i] & (cnt[i] == CNT_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cfg_q        <= CFG_RESET;
      int_status   <= '0;
      int_mask     <= '0;
      regb_rdata_o <= '0;
      regb_ack_o   <= 1'b0;
      regb_error_o <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      regb_ack_o   <= req;
      regb_error_o <= req & err;
      if (regb_ren_i) regb_rdata_o <= err ? '0 : rd_val;
      if (wr_ok && hit_cfg) cfg_q <= regb_wdata_i;
      if (wr_ok && hit_msk) int_mask <= regb_wdata_i[NUM_CNT-1:0];
      // A saturation event in the same cycle as its W1C clear wins.
      int_status <= sat_set |
                    (int_status & ~((wr_ok && hit_ist) ? regb_wdata_i[NUM_CNT-1:0] : '0));
      irq_o <= |(int_status & int_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clr_rd[i]) cnt[i] <= REG_DATA_WIDTH'(cnt_inc_i[i]);
        else if (cnt_inc_i[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + REG_DATA_WIDTH'(1);
      end
    end
  end

  assign cfg_o = cfg_q;

endmodule

// File: doc/xge_mac_stat_reg_block.md
XGE_MAC_STAT_REG_BLOCK -- requirements
Module: xge_mac_stat_reg_block

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH, default 32, register/data width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter BASE_ADDRESS, default 0, byte offset of register map.
REQ-004 SHALL have parameter NUM_CNT, default 4, number of statistics counters, legal range 1..REG_DATA_WIDTH.
REQ-005 SHALL have parameter CFG_RESET, default 'h4, CONFIG reset value.
REQ-006 SHALL have ports: clk  in  1  sole clock; resetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port regb_addr_i  in  REG_ADDR_WIDTH  byte address.
REQ-008 SHALL have ports regb_wdata_i  in  REG_DATA_WIDTH  write data; regb_wen_i  in  1  write request; regb_ren_i  in  1  read request.
REQ-009 SHALL have ports regb_rdata_o  out  REG_DATA_WIDTH  read data; regb_ack_o  out  1  response; regb_error_o  out  1  error flag.
REQ-010 SHALL have ports cnt_inc_i  in  NUM_CNT  per-counter increment strobe; status_i  in  REG_DATA_WIDTH  live hardware status.
REQ-011 SHALL have ports cfg_o  out  REG_DATA_WIDTH  CONFIG contents; irq_o  out  1  interrupt.

Function
REQ-012 Map (offset from BASE_ADDRESS) SHALL be: 0x0 CONFIG RW; 0x4 STATUS RO (=status_i); 0x8 INT_STATUS W1C; 0xC INT_MASK RW; 0x10+4*i CNT[i] RO, i=0..NUM_CNT-1.
REQ-013 Decode SHALL be exact full-address match; any other address, including misaligned, is unmapped.
REQ-014 Each cycle with regb_wen_i or regb_ren_i high is one request; regb_ack_o SHALL be high exactly in the following cycle, one ack per request, back-to-back requests giving back-to-back acks.
REQ-015 regb_error_o SHALL be high with that ack when: wen and ren both high, address unmapped, or write to STATUS/CNT; erroneous requests SHALL have no register side effect.
REQ-016 Read data SHALL be registered: regb_rdata_o valid in the ack cycle, holds last value otherwise; errored reads SHALL return 0.
REQ-017 Writes SHALL take effect at the request-cycle clock edge; a read of the same register in the next cycle returns the new value.
REQ-018 Writing INT_STATUS SHALL clear bits where wdata is 1; only low NUM_CNT bits exist, upper bits read 0.
REQ-019 CNT[i] SHALL increment by 1 each cycle cnt_inc_i[i] is high, saturate at all-ones, never wrap.
REQ-020 INT_STATUS[i] SHALL set in the cycle CNT[i] transitions to all-ones; simultaneous set and W1C clear SHALL leave the bit set.
REQ-021 INT_MASK writable bits SHALL be low NUM_CNT bits; upper bits read 0.
REQ-022 irq_o SHALL be registered |(INT_STATUS & INT_MASK), one cycle after the state change.
REQ-023 cfg_o SHALL equal CONFIG continuously.

Reset
REQ-024 On resetn low at a clk edge: CONFIG=CFG_RESET, INT_STATUS=0, INT_MASK=0, all CNT=0, regb_rdata_o=0, regb_ack_o=0, regb_error_o=0, irq_o=0.
REQ-025 A request in flight when reset asserts SHALL be dropped; no ack after reset release.
REQ-026 Requests and cnt_inc_i while resetn low SHALL be ignored.

Configuration
REQ-027 Macro XGE_MAC_STAT_CLR_ON_READ_EN defined: a successful read of CNT[i] returns the pre-clear value and CNT[i] becomes 0, or 1 if cnt_inc_i[i] is high that cycle.
REQ-028 Macro undefined: CNT reads are non-destructive; counters clear only on reset.

Verification
REQ-029 Reset release, read 0x0 -> ack next cycle, rdata=0x00000004, error=0; cfg_o=0x4.
REQ-030 Write 0x0=0xA5A5A5A5, read 0x0 next cycle -> rdata=0xA5A5A5A5; write 0x4 -> ack+error, STATUS unchanged; read 0x40 -> ack+error, rdata=0.
REQ-031 wen=ren=1 at 0xC -> ack+error, INT_MASK stays 0.
REQ-032 Force CNT[1] via 5 strobes, read 0x14 -> 5; with macro second read -> 0, without -> 5.
REQ-033 INT_MASK=0x2, strobe cnt_inc_i[1] until saturation -> CNT[1]=0xFFFFFFFF held, INT_STATUS=0x2, irq_o=1 one cycle later; W1C 0x2 -> irq_o=0.
REQ-034 W1C of INT_STATUS[1] in the saturation cycle -> bit remains 1; resetn low mid read -> no ack, all outputs reset values.
